uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive block: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
//  Sits between the external RX pad and the core's byte consumer.
//  It is the far end of the UART_Transmitter link and uses the same CLKS_PER_BIT convention.
//  Each bit is sampled once at its centre. A received byte is reported with a one-cycle valid pulse.
//  A bad stop bit is reported as a framing error.
// PARAMETERS
//  CLKS_PER_BIT  87  i_clock cycles per bit = f(i_clock)/baud. Must be >= 4 (e.g. 10 MHz / 115200 = 87).
// PORTS
//  i_clock        in   1  system clock; all logic is on its rising edge
//  i_reset_n      in   1  asynchronous, active-low reset
//  i_RX_Serial    in   1  asynchronous serial line; idles high
//  o_RX_Byte      out  8  last correctly framed byte; holds until the next good byte
//  o_RX_DV        out  1  one-cycle pulse: o_RX_Byte was updated this cycle
//  o_RX_Active    out  1  high while a frame is being received
//  o_Frame_Err    out  1  one-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=S_IDLE; all counters=0.
//    - o_RX_Byte=0, o_RX_DV=0, o_RX_Active=0, o_Frame_Err=0.
//    - Both synchronizer flops preset to 1 (idle).
//  - Input sync: i_RX_Serial passes through 2 flops to give rx_s. The FSM sees only rx_s (2-cycle delay).
//  - Bit counter width is $clog2(CLKS_PER_BIT); the bit index is 3 bits.
//  - FSM:
//    - S_IDLE:
//      - count=0, index=0, o_RX_Active=0.
//      - rx_s==0 -> S_START.
//    - S_START:
//      - o_RX_Active=1.
//      - Count to (CLKS_PER_BIT-1)/2 (integer division); that cycle is the start-bit centre.
//      - At the centre: rx_s==0 -> count=0, go to S_DATA. rx_s==1 -> glitch: go to S_IDLE, no pulse.
//    - S_DATA:
//      - Count to CLKS_PER_BIT-1, then shift-register[index] <= rx_s and count=0.
//      - index<7 -> index+1. index==7 -> index=0, go to S_STOP.
//    - S_STOP:
//      - Count to CLKS_PER_BIT-1, then sample rx_s.
//      - rx_s==1 -> o_RX_Byte<=shift-register and o_RX_DV=1 for exactly one cycle, go to S_CLEANUP.
//      - rx_s==0 -> o_Frame_Err=1 for one cycle, o_RX_Byte unchanged, go to S_WAIT_IDLE.
//    - S_CLEANUP: one cycle; o_RX_Active=0; go to S_IDLE.
//    - S_WAIT_IDLE:
//      - Stay while rx_s==0; this absorbs break conditions, so no re-trigger.
//      - rx_s==1 -> S_IDLE. o_RX_Active=0 throughout.
//    - Unused state encodings -> S_IDLE.
//  - Latency: o_RX_DV rises in the cycle after the stop-bit sample. Measured from the i_RX_Serial
//    falling edge: 2 + ((CLKS_PER_BIT-1)/2+1) + 9*CLKS_PER_BIT + 1 cycles (+/-1 for async edge phase).
//  - Back-to-back frames: a start edge arriving in S_IDLE right after S_CLEANUP is accepted.
//    A stop bit of exactly 1 bit time is tolerated.
//  - o_RX_DV and o_Frame_Err are mutually exclusive and never high on consecutive cycles.
//  - Reset mid-frame: immediate return to S_IDLE; the partial byte is discarded; no pulses.
// TESTING (bench uses CLKS_PER_BIT=87 and a behavioural TX model; UART_Transmitter loopback also allowed)
//  1. Frame 0xA5, good stop -> one o_RX_DV pulse with o_RX_Byte=8'hA5 at the latency above;
//     o_Frame_Err stays 0.
//  2. Frames 0x00, 0xFF, 0x3C back-to-back, 1-bit stops -> three o_RX_DV pulses with those bytes
//     in order; no errors.
//  3. 20-cycle low glitch on an idle line -> FSM returns to S_IDLE; o_RX_Active pulses high;
//     no o_RX_DV, no o_Frame_Err.
//  4. Frame 0x5A with stop bit low, then line held low for 3 bit times, then high, then frame 0x81 ->
//     o_Frame_Err pulses once; o_RX_Byte keeps its previous value; 0x81 is then received correctly.
//  5. Assert i_reset_n low during data bit 4 of frame 0xC3, release, send 0x12 ->
//     no pulse for 0xC3; all outputs 0 during reset; 0x12 is received correctly.
//  6. Baud skew: frames 0x96 sent at +/-3% bit period -> o_RX_Byte=8'h96, no framing error.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input sync, centre sampling, one-cycle o_RX_DV / o_Frame_Err pulses; no backpressure.
// Latency: o_RX_DV about 2 + ((CLKS_PER_BIT-1)/2+1) + 9*CLKS_PER_BIT + 1 cycles after the start edge.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_RX_Active,
  output logic       o_Frame_Err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_CLEANUP   = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    index_q, index_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    rx_meta_d = i_RX_Serial;
    rx_s_d    = rx_meta_q;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        index_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // A start bit that is gone by its centre was a glitch.
        if (count_q == CNT_HALF) begin
          count_d = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DATA: begin
        if (count_q == CNT_FULL) begin
          count_d          = '0;
          shift_d[index_q] = rx_s_q;
          if (index_q == 3'd7) begin
            index_d = '0;
            state_d = S_STOP;
          end else begin
            index_d = index_q + 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_STOP: begin
        if (count_q == CNT_FULL) begin
          count_d = '0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_CLEANUP: state_d = S_IDLE;
      // Hold off re-triggering until a break releases the line.
      S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      index_q   <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      index_q   <= index_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  assign o_RX_Byte   = byte_q;
  assign o_RX_DV     = dv_q;
  assign o_Frame_Err = ferr_q;
  assign o_RX_Active = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: behavioural 8N1 transmitter, pulse monitor and a byte/latency scoreboard.
module tb_uart_receiver;

  localparam int C   = 87;
  localparam int LAT = 2 + ((C - 1) / 2 + 1) + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_dv, rx_active, frame_err;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_RX_Serial(rx),
    .o_RX_Byte  (rx_byte),
    .o_RX_DV    (rx_dv),
    .o_RX_Active(rx_active),
    .o_Frame_Err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every received byte with its cycle, counts error pulses and active cycles.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         fe_cnt = 0;
  int         act_cnt = 0;
  logic       prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (rx_dv) begin
      got_q.push_back(rx_byte);
      got_cyc.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (rx_active) act_cnt++;
    if (rx_dv || frame_err) begin
      n_cmp++;
      if ((rx_dv && frame_err) || prev_pulse) begin
        n_bad++;
        $display("FAIL pulse_rules: dv=%0b fe=%0b prev_pulse=%0b, required one isolated pulse",
                 rx_dv, frame_err, prev_pulse);
      end
    end
    prev_pulse = rx_dv || frame_err;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Bit k ends at round((k+1)*C*pct/100) cycles after the start edge; leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] d, input int pct, input bit stop_ok, output int fall);
    logic [9:0] bits;
    int t_prev, t_end;
    bits   = {stop_ok, d, 1'b0};
    t_prev = 0;
    fall   = cyc;
    for (int k = 0; k < 10; k++) begin
      rx    = bits[k];
      t_end = ((k + 1) * C * pct + 50) / 100;
      repeat (t_end - t_prev) @(negedge clk);
      t_prev = t_end;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         pct;
    bit         stop_ok;
    int         gap;
    bit         exp_dv;
    bit         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t       vt[6];
  int         falls[6];
  int         base, fe0, act0, j, nexp, nfe, f;
  logic [7:0] last_good;
  logic [7:0] exp_q[$];
  int         exp_fall[$];

  initial begin
    vt[0] = '{8'hA5, 100, 1'b1, 200, 1'b1, 1'b0, 8'hA5};
    vt[1] = '{8'h00, 100, 1'b1, 0,   1'b1, 1'b0, 8'h00};
    vt[2] = '{8'hFF, 100, 1'b1, 0,   1'b1, 1'b0, 8'hFF};
    vt[3] = '{8'h3C, 100, 1'b1, 200, 1'b1, 1'b0, 8'h3C};
    vt[4] = '{8'h96, 103, 1'b1, 200, 1'b1, 1'b0, 8'h96};
    vt[5] = '{8'h96, 97,  1'b1, 200, 1'b1, 1'b0, 8'h96};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_byte", rx_byte, 0);
    chk("rst_dv", rx_dv, 0);
    chk("rst_active", rx_active, 0);
    chk("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    idle(20);

    // Table: single frame, back-to-back frames with 1-bit stops, baud skew
    base = got_q.size();
    fe0  = fe_cnt;
    nexp = 0;
    nfe  = 0;
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].data, vt[i].pct, vt[i].stop_ok, falls[i]);
      idle(vt[i].gap);
      nexp += vt[i].exp_dv;
      nfe  += vt[i].exp_fe;
    end
    chk("tbl_count", got_q.size() - base, nexp);
    chk("tbl_ferr", fe_cnt - fe0, nfe);
    j = base;
    for (int i = 0; i < 6; i++) begin
      if (vt[i].exp_dv && j < got_q.size()) begin
        chk("tbl_byte", got_q[j], vt[i].exp_byte);
        chk_rng("tbl_latency", got_cyc[j] - falls[i], LAT - 1, LAT + 1);
        j++;
      end
    end
    last_good = 8'h96;

    // Glitch on an idle line
    base = got_q.size();
    fe0  = fe_cnt;
    act0 = act_cnt;
    rx   = 1'b0;
    repeat (20) @(negedge clk);
    idle(200);
    chk("glitch_dv", got_q.size() - base, 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    chk("glitch_active_seen", (act_cnt - act0) > 0, 1);
    chk("glitch_active_end", rx_active, 0);

    // Framing error followed by a break, then a good frame
    base = got_q.size();
    fe0  = fe_cnt;
    send_frame(8'h5A, 100, 1'b0, f);
    repeat (3 * C) @(negedge clk);
    chk("ferr_count", fe_cnt - fe0, 1);
    chk("ferr_byte_hold", rx_byte, last_good);
    chk("ferr_no_dv", got_q.size() - base, 0);
    idle(100);
    send_frame(8'h81, 100, 1'b1, f);
    idle(200);
    chk("ferr_recover_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("ferr_recover_byte", got_q[base], 8'h81);
    chk("ferr_total", fe_cnt - fe0, 1);
    last_good = 8'h81;

    // Reset during data bit 4 of 0xC3, held until the line is idle
    base = got_q.size();
    fe0  = fe_cnt;
    fork
      send_frame(8'hC3, 100, 1'b1, f);
      begin
        repeat (5 * C + C / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_byte", rx_byte, 0);
        chk("mrst_dv", rx_dv, 0);
        chk("mrst_active", rx_active, 0);
        chk("mrst_ferr", frame_err, 0);
      end
    join
    idle(20);
    rst_n = 1'b1;
    idle(50);
    chk("mrst_no_pulse", got_q.size() - base, 0);
    send_frame(8'h12, 100, 1'b1, f);
    idle(200);
    chk("mrst_recover_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("mrst_recover_byte", got_q[base], 8'h12);
    chk("mrst_ferr", fe_cnt - fe0, 0);
    last_good = 8'h12;

    // Random frames against the reference model
    base = got_q.size();
    fe0  = fe_cnt;
    nfe  = 0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      int         pct;
      bit         ok;
      d   = 8'($urandom);
      pct = $urandom_range(98, 102);
      ok  = ($urandom_range(0, 4) != 0);
      send_frame(d, pct, ok, f);
      if (ok) begin
        exp_q.push_back(d);
        exp_fall.push_back(f);
        last_good = d;
        idle($urandom_range(0, 30));
      end else begin
        nfe++;
        repeat ($urandom_range(1, 2 * C)) @(negedge clk);
        idle(60);
      end
    end
    idle(200);
    chk("rand_count", got_q.size() - base, exp_q.size());
    chk("rand_ferr", fe_cnt - fe0, nfe);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        chk("rand_byte", got_q[base + i], exp_q[i]);
        chk_rng("rand_latency", got_cyc[base + i] - exp_fall[i], LAT - 1, LAT + 1);
      end
    end
    chk("rand_final_byte", rx_byte, last_good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
